// File: rtl/core_pkg.sv
// Shared definitions for the core sequencer: FSM state encoding and the
// RV32 major opcodes the sequencer understands.
package core_pkg;

  typedef enum logic [2:0] {
    FETCH   = 3'd0,
    DECODE  = 3'd1,
    EXECUTE = 3'd2,
    MEM     = 3'd3,
    WB      = 3'd4,
    TRAP    = 3'd5
  } state_t;

  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;

  function automatic logic is_legal(input logic [6:0] op);
    return (op == OP_R) || (op == OP_I) || (op == OP_LOAD) || (op == OP_STORE);
  endfunction

  function automatic logic is_mem(input logic [6:0] op);
    return (op == OP_LOAD) || (op == OP_STORE);
  endfunction

endpackage

// File: rtl/core_sequencer.sv
// Multi-cycle instruction sequencer: FETCH/DECODE/EXECUTE/MEM/WB control FSM
// with a sticky illegal-opcode trap and a retired-instruction counter.
module core_sequencer
  import core_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [6:0]  opcode,
  input  logic        imem_ready,
  input  logic        dmem_ready,
  output logic        imem_req,
  output logic        ir_load,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic        rf_we,
  output logic        pc_en,
  output logic        illegal,
  output logic [31:0] retire_cnt,
  output logic [2:0]  state
);

  state_t state_reg;
  state_t state_next;
  logic   illegal_reg;
  logic   retire;

  assign state   = state_reg;
  assign illegal = illegal_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= FETCH;
      illegal_reg <= 1'b0;
      retire_cnt  <= 32'd0;
    end else begin
      state_reg <= state_next;
      if (state_next == TRAP)
        illegal_reg <= 1'b1;
      // Counter wraps naturally; no overflow indication is wanted.
      if (retire)
        retire_cnt <= retire_cnt + 32'd1;
    end
  end

  always_comb begin
    state_next = state_reg;
    imem_req   = 1'b0;
    ir_load    = 1'b0;
    dmem_req   = 1'b0;
    dmem_we    = 1'b0;
    rf_we      = 1'b0;
    pc_en      = 1'b0;
    retire     = 1'b0;

    case (state_reg)
      FETCH: begin
        imem_req = 1'b1;
        if (imem_ready) begin
          ir_load    = 1'b1;
          state_next = DECODE;
        end
      end
      DECODE: begin
        state_next = is_legal(opcode) ? EXECUTE : TRAP;
      end
      EXECUTE: begin
        state_next = is_mem(opcode) ? MEM : WB;
      end
      MEM: begin
        dmem_req = 1'b1;
        dmem_we  = (opcode == OP_STORE);
        if (dmem_ready) begin
          // Stores have nothing to write back, so they retire straight from MEM.
          if (opcode == OP_STORE) begin
            pc_en      = 1'b1;
            retire     = 1'b1;
            state_next = FETCH;
          end else begin
            state_next = WB;
          end
        end
      end
      WB: begin
        rf_we      = 1'b1;
        pc_en      = 1'b1;
        retire     = 1'b1;
        state_next = FETCH;
      end
      TRAP: begin
        state_next = TRAP;
      end
      default: begin
        state_next = FETCH;
      end
    endcase
  end

endmodule

// File: tb/tb_core_sequencer.sv
// Directed bench for core_sequencer: per-cycle expectations are queued as
// inputs are driven and compared once the outputs have settled.
module tb_core_sequencer;
  import core_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [6:0]  opcode;
  logic        imem_ready;
  logic        dmem_ready;
  logic        imem_req;
  logic        ir_load;
  logic        dmem_req;
  logic        dmem_we;
  logic        rf_we;
  logic        pc_en;
  logic        illegal;
  logic [31:0] retire_cnt;
  logic [2:0]  state;

  core_sequencer dut (
    .clk        (clk),
    .rst        (rst),
    .opcode     (opcode),
    .imem_ready (imem_ready),
    .dmem_ready (dmem_ready),
    .imem_req   (imem_req),
    .ir_load    (ir_load),
    .dmem_req   (dmem_req),
    .dmem_we    (dmem_we),
    .rf_we      (rf_we),
    .pc_en      (pc_en),
    .illegal    (illegal),
    .retire_cnt (retire_cnt),
    .state      (state)
  );

  always #5 clk = ~clk;

  // Strobe vector order: {imem_req, ir_load, dmem_req, dmem_we, rf_we, pc_en, illegal}
  localparam logic [6:0] F_IDLE   = 7'b1000000;
  localparam logic [6:0] F_LOAD   = 7'b1100000;
  localparam logic [6:0] QUIET    = 7'b0000000;
  localparam logic [6:0] MEM_RD   = 7'b0010000;
  localparam logic [6:0] MEM_ST   = 7'b0011010;
  localparam logic [6:0] WB_S     = 7'b0000110;
  localparam logic [6:0] TRAP_S   = 7'b0000001;

  typedef struct {
    string       tag;
    state_t      st;
    logic [6:0]  strb;
    logic [31:0] cnt;
  } exp_t;

  exp_t sb[$];
  int   passes = 0;
  int   total  = 0;

  task automatic cyc(input string tag, input logic r, input logic im, input logic dm,
                     input state_t st, input logic [6:0] strb, input logic [31:0] cnt);
    exp_t       e;
    logic [6:0] obs;
    @(negedge clk);
    rst        = r;
    imem_ready = im;
    dmem_ready = dm;
    e.tag  = tag;
    e.st   = st;
    e.strb = strb;
    e.cnt  = cnt;
    sb.push_back(e);
    #2;
    e   = sb.pop_front();
    obs = {imem_req, ir_load, dmem_req, dmem_we, rf_we, pc_en, illegal};
    total++;
    assert (state === e.st) passes++;
    else $error("FAIL %s state: got %0d expected %0d", e.tag, state, e.st);
    total++;
    assert (obs === e.strb) passes++;
    else $error("FAIL %s strobes: got %b expected %b", e.tag, obs, e.strb);
    total++;
    assert (retire_cnt === e.cnt) passes++;
    else $error("FAIL %s retire_cnt: got %h expected %h", e.tag, retire_cnt, e.cnt);
    $display("cycle %-10s r=%b im=%b dm=%b state=%0d strb=%b cnt=%h", e.tag, r, im, dm,
             state, obs, retire_cnt);
  endtask

  initial begin
    rst        = 1'b1;
    opcode     = OP_R;
    imem_ready = 1'b0;
    dmem_ready = 1'b0;
    repeat (2) @(posedge clk);

    cyc("reset", 0, 0, 0, FETCH, F_IDLE, 32'd0);

    // R-type, imem_ready held high throughout (ignored outside FETCH)
    opcode = OP_R;
    cyc("r_fetch", 0, 1, 0, FETCH,   F_LOAD, 32'd0);
    cyc("r_dec",   0, 1, 0, DECODE,  QUIET,  32'd0);
    cyc("r_exe",   0, 1, 0, EXECUTE, QUIET,  32'd0);
    cyc("r_wb",    0, 1, 0, WB,      WB_S,   32'd0);

    // LOAD with three data-memory wait cycles
    opcode = OP_LOAD;
    cyc("ld_fetch", 0, 1, 0, FETCH,   F_LOAD, 32'd1);
    cyc("ld_dec",   0, 1, 0, DECODE,  QUIET,  32'd1);
    cyc("ld_exe",   0, 1, 1, EXECUTE, QUIET,  32'd1);
    cyc("ld_mem0",  0, 0, 0, MEM,     MEM_RD, 32'd1);
    cyc("ld_mem1",  0, 0, 0, MEM,     MEM_RD, 32'd1);
    cyc("ld_mem2",  0, 0, 0, MEM,     MEM_RD, 32'd1);
    cyc("ld_mem3",  0, 0, 1, MEM,     MEM_RD, 32'd1);
    cyc("ld_wb",    0, 0, 1, WB,      WB_S,   32'd1);

    // STORE, zero-wait
    opcode = OP_STORE;
    cyc("st_fetch", 0, 1, 0, FETCH,   F_LOAD, 32'd2);
    cyc("st_dec",   0, 0, 0, DECODE,  QUIET,  32'd2);
    cyc("st_exe",   0, 0, 0, EXECUTE, QUIET,  32'd2);
    cyc("st_mem",   0, 0, 1, MEM,     MEM_ST, 32'd2);
    cyc("st_back",  0, 0, 0, FETCH,   F_IDLE, 32'd3);

    // Reset while a LOAD is stalled in MEM
    opcode = OP_LOAD;
    cyc("rm_fetch", 0, 1, 0, FETCH,   F_LOAD, 32'd3);
    cyc("rm_dec",   0, 0, 0, DECODE,  QUIET,  32'd3);
    cyc("rm_exe",   0, 0, 0, EXECUTE, QUIET,  32'd3);
    cyc("rm_mem",   0, 0, 0, MEM,     MEM_RD, 32'd3);
    cyc("rm_rst",   1, 0, 0, MEM,     MEM_RD, 32'd3);
    cyc("rm_after", 0, 0, 0, FETCH,   F_IDLE, 32'd0);

    // Counter wrap: preload all-ones while idling in FETCH
    force dut.retire_cnt = 32'hFFFF_FFFF;
    #1;
    release dut.retire_cnt;
    opcode = OP_R;
    cyc("wr_fetch", 0, 1, 0, FETCH,   F_LOAD, 32'hFFFF_FFFF);
    cyc("wr_dec",   0, 0, 0, DECODE,  QUIET,  32'hFFFF_FFFF);
    cyc("wr_exe",   0, 0, 0, EXECUTE, QUIET,  32'hFFFF_FFFF);
    cyc("wr_wb",    0, 0, 0, WB,      WB_S,   32'hFFFF_FFFF);
    cyc("wr_back",  0, 0, 0, FETCH,   F_IDLE, 32'd0);

    // Illegal opcode traps until reset
    opcode = 7'b1111111;
    cyc("tr_fetch", 0, 1, 0, FETCH,  F_LOAD, 32'd0);
    cyc("tr_dec",   0, 1, 1, DECODE, QUIET,  32'd0);
    for (int i = 0; i < 10; i++)
      cyc("tr_hold", 0, 1, 1, TRAP, TRAP_S, 32'd0);
    cyc("tr_rst",   1, 1, 1, TRAP,   TRAP_S, 32'd0);
    cyc("tr_after", 0, 0, 0, FETCH,  F_IDLE, 32'd0);

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule
